// File: rtl/fft_mem_scheduler.sv
// Phase scheduler and single-port arbiter for the FFT working RAM.
// Hands the RAM port to the loader, then the FFT engine, then the readout.
module fft_mem_scheduler #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int BITREV = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic [1:0]        phase,
    output logic              frame_done,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic              fft_start,
    input  logic              fft_valid,
    output logic              fft_ready,
    input  logic              fft_we,
    input  logic [ADDR_W-1:0] fft_addr,
    input  logic [DATA_W-1:0] fft_wdata,
    output logic [DATA_W-1:0] fft_rdata,
    output logic              fft_rvalid,
    input  logic              fft_done,
    input  logic              rd_valid,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_rdata,
    output logic              rd_rvalid,
    output logic [ADDR_W-1:0] rd_index,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        UNLOAD  = 2'd3
    } phase_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    phase_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_rev;
    logic              rvalid_q;
    logic              tag_q;    // 1 = outstanding read belongs to readout
    logic              ld_acc;
    logic              fft_acc;
    logic              rd_acc;
    logic              fft_rd_acc;

    assign phase     = state;
    assign busy      = (state != IDLE);
    assign ld_ready  = (state == LOAD);
    assign fft_ready = (state == COMPUTE);
    assign rd_ready  = (state == UNLOAD);

    assign ld_acc     = ld_valid  & ld_ready;
    assign fft_acc    = fft_valid & fft_ready;
    assign rd_acc     = rd_valid  & rd_ready;
    assign fft_rd_acc = fft_acc & ~fft_we;

    assign frame_done = rd_acc & (cnt == LAST);

    assign fft_rdata  = mem_dout;
    assign rd_rdata   = mem_dout;
    assign fft_rvalid = rvalid_q & ~tag_q;
    assign rd_rvalid  = rvalid_q &  tag_q;

    always_comb begin
        cnt_rev = '0;
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            cnt_rev[i] = cnt[ADDR_W-1-i];
        end
    end

    always_comb begin
        mem_ce  = ld_acc | fft_acc | rd_acc;
        mem_wre = ld_acc | (fft_acc & fft_we);
        mem_ad  = '0;
        mem_din = '0;
        if (ld_acc) begin
            mem_ad  = cnt;
            mem_din = ld_data;
        end else if (fft_acc) begin
            mem_ad  = fft_addr;
            mem_din = fft_wdata;
        end else if (rd_acc) begin
            mem_ad  = (BITREV != 0) ? cnt_rev : cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            fft_start <= 1'b0;
            rvalid_q  <= 1'b0;
            tag_q     <= 1'b0;
            rd_index  <= '0;
        end else begin
            fft_start <= 1'b0;
            // Return path stays live across the UNLOAD->IDLE edge so the last read is delivered.
            rvalid_q  <= rd_acc | fft_rd_acc;
            if (rd_acc | fft_rd_acc) tag_q <= rd_acc;
            if (rd_acc) rd_index <= cnt;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (ld_acc) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state     <= COMPUTE;
                            fft_start <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (fft_done) begin
                        state <= UNLOAD;
                        cnt   <= '0;
                    end
                end
                UNLOAD: begin
                    if (rd_acc) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_mem_scheduler.sv
// Directed bench: two schedulers (natural and bit-reversed readout) share
// stimulus, each with its own registered-read RAM model.
module tb_fft_mem_scheduler;

    localparam int AW = 3;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start;
    logic          ld_valid, fft_valid, fft_we, fft_done, rd_valid;
    logic [DW-1:0] ld_data, fft_wdata;
    logic [AW-1:0] fft_addr;

    logic          busy0, frame_done0, ld_ready0, fft_start0, fft_ready0, fft_rvalid0;
    logic          rd_ready0, rd_rvalid0, ce0, wre0;
    logic [1:0]    phase0;
    logic [DW-1:0] fft_rdata0, rd_rdata0, din0, dout0;
    logic [AW-1:0] rd_index0, ad0;

    logic          busy1, frame_done1, ld_ready1, fft_start1, fft_ready1, fft_rvalid1;
    logic          rd_ready1, rd_rvalid1, ce1, wre1;
    logic [1:0]    phase1;
    logic [DW-1:0] fft_rdata1, rd_rdata1, din1, dout1;
    logic [AW-1:0] rd_index1, ad1;

    logic [DW-1:0] ram0 [8];
    logic [DW-1:0] ram1 [8];

    always @(posedge clk) begin
        if (ce0) begin
            if (wre0) ram0[ad0] <= din0;
            else      dout0     <= ram0[ad0];
        end
        if (ce1) begin
            if (wre1) ram1[ad1] <= din1;
            else      dout1     <= ram1[ad1];
        end
    end

    fft_mem_scheduler #(.ADDR_W(AW), .DATA_W(DW), .BITREV(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .busy(busy0), .phase(phase0),
        .frame_done(frame_done0), .ld_valid(ld_valid), .ld_ready(ld_ready0),
        .ld_data(ld_data), .fft_start(fft_start0), .fft_valid(fft_valid),
        .fft_ready(fft_ready0), .fft_we(fft_we), .fft_addr(fft_addr),
        .fft_wdata(fft_wdata), .fft_rdata(fft_rdata0), .fft_rvalid(fft_rvalid0),
        .fft_done(fft_done), .rd_valid(rd_valid), .rd_ready(rd_ready0),
        .rd_rdata(rd_rdata0), .rd_rvalid(rd_rvalid0), .rd_index(rd_index0),
        .mem_ce(ce0), .mem_wre(wre0), .mem_ad(ad0), .mem_din(din0), .mem_dout(dout0)
    );

    fft_mem_scheduler #(.ADDR_W(AW), .DATA_W(DW), .BITREV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .busy(busy1), .phase(phase1),
        .frame_done(frame_done1), .ld_valid(ld_valid), .ld_ready(ld_ready1),
        .ld_data(ld_data), .fft_start(fft_start1), .fft_valid(fft_valid),
        .fft_ready(fft_ready1), .fft_we(fft_we), .fft_addr(fft_addr),
        .fft_wdata(fft_wdata), .fft_rdata(fft_rdata1), .fft_rvalid(fft_rvalid1),
        .fft_done(fft_done), .rd_valid(rd_valid), .rd_ready(rd_ready1),
        .rd_rdata(rd_rdata1), .rd_rvalid(rd_rvalid1), .rd_index(rd_index1),
        .mem_ce(ce1), .mem_wre(wre1), .mem_ad(ad1), .mem_din(din1), .mem_dout(dout1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] brev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    initial begin
        reset = 1'b1; start = 1'b1;
        ld_valid = 1'b0; ld_data = '0;
        fft_valid = 1'b0; fft_we = 1'b0; fft_addr = '0; fft_wdata = '0; fft_done = 1'b0;
        rd_valid = 1'b0;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_phase", phase0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_ready", {ld_ready0, fft_ready0, rd_ready0}, 0);
        chk("rst_mem", {ce0, wre0}, 0);
        chk("rst_rvalid", {fft_rvalid0, rd_rvalid0}, 0);
        chk("rst_index", rd_index0, 0);
        chk("rst_pulses", {frame_done0, fft_start0}, 0);

        // LOAD with foreign requesters held active and one gap
        rd_valid = 1'b1; fft_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("load_phase", phase0, 1);
        chk("load_busy", busy0, 1);
        chk("load_readies", {ld_ready0, fft_ready0, rd_ready0}, 3'b100);
        chk("load_idle_ce", ce0, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                ld_valid = 1'b0;
                #1;
                chk("load_gap_ce", ce0, 0);
                tick();
            end
            ld_valid = 1'b1;
            ld_data  = 32'h0001_0000 + i;
            #1;
            chk("load_ce_wre", {ce0, wre0}, 2'b11);
            chk("load_ad", ad0, i);
            chk("load_din", din0, 32'h0001_0000 + i);
            chk("load_no_rvalid", {fft_rvalid0, rd_rvalid0}, 0);
            tick();
        end
        ld_valid = 1'b0; rd_valid = 1'b0; fft_valid = 1'b0;
        #1;
        chk("comp_phase", phase0, 2);
        chk("comp_fft_start", fft_start0, 1);
        chk("comp_readies", {ld_ready0, fft_ready0, rd_ready0}, 3'b010);
        chk("comp_idle_ce", ce0, 0);

        // start during COMPUTE is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("comp_start_ign", phase0, 2);
        chk("comp_start_once", fft_start0, 0);

        fft_valid = 1'b1; fft_we = 1'b1; fft_addr = 3'd3; fft_wdata = 32'hAAAA_5555;
        #1;
        chk("fft_wr_mem", {ce0, wre0}, 2'b11);
        chk("fft_wr_ad", ad0, 3);
        chk("fft_wr_din", din0, 32'hAAAA_5555);
        tick();
        fft_we = 1'b0;
        #1;
        chk("fft_rd_mem", {ce0, wre0}, 2'b10);
        chk("fft_wr_no_rvalid", fft_rvalid0, 0);
        tick();
        fft_we = 1'b1; fft_wdata = 32'h0001_0003;
        #1;
        chk("fft_rvalid", fft_rvalid0, 1);
        chk("fft_rdata", fft_rdata0, 32'hAAAA_5555);
        chk("fft_rd_not_rd", rd_rvalid0, 0);
        tick();
        fft_we = 1'b0; fft_addr = 3'd5; fft_done = 1'b1;
        #1;
        chk("fft_done_rd_ce", {ce0, wre0}, 2'b10);
        tick();
        fft_valid = 1'b0; fft_done = 1'b0;
        #1;
        chk("unl_phase", phase0, 3);
        chk("done_rd_rvalid", fft_rvalid0, 1);
        chk("done_rd_rdata", fft_rdata0, 32'h0001_0005);
        chk("unl_readies", {ld_ready0, fft_ready0, rd_ready0}, 3'b001);

        // UNLOAD: natural order on dut0, bit-reversed on dut1
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1;
            #1;
            chk("unl_mem", {ce0, wre0}, 2'b10);
            chk("unl_ad_nat", ad0, i);
            chk("unl_ad_rev", ad1, brev3(3'(i)));
            chk("unl_frame_done", frame_done0, (i == 7) ? 1 : 0);
            if (i > 0) begin
                chk("unl_rvalid", rd_rvalid0, 1);
                chk("unl_rdata_nat", rd_rdata0, 32'h0001_0000 + (i - 1));
                chk("unl_index_nat", rd_index0, i - 1);
                chk("unl_rdata_rev", rd_rdata1, 32'h0001_0000 + brev3(3'(i - 1)));
                chk("unl_index_rev", rd_index1, i - 1);
            end
            tick();
        end
        rd_valid = 1'b0;
        #1;
        chk("end_phase", phase0, 0);
        chk("end_busy", busy0, 0);
        chk("end_last_rvalid", rd_rvalid0, 1);
        chk("end_last_rdata", rd_rdata0, 32'h0001_0007);
        chk("end_last_index", rd_index0, 7);
        chk("end_frame_done", frame_done0, 0);

        // Reset after 5 loads, then restart
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1; ld_data = 32'h1234_0000 + i;
            tick();
        end
        ld_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_phase", phase0, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_ld_ready", ld_ready0, 0);
        start = 1'b1;
        tick();
        start = 1'b0; ld_valid = 1'b1; ld_data = 32'h5555_0000;
        #1;
        chk("restart_phase", phase0, 1);
        chk("restart_ad", ad0, 0);
        chk("restart_ce", {ce0, wre0}, 2'b11);
        tick();
        ld_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
